// File: rtl/lc3b_pkg.sv
// ---------------------------------------------------------------------------
// lc3b_pkg
// Shared constants, types and helpers for the LC-3b pipeline front end.
//   WORD        : datapath width
//   PCMUX_*     : encodings of the MEM-stage PC source select
//   INSTR_STEP  : PC increment per fetched instruction (byte addressed)
//   RESET_PC    : value the core's PC register takes on reset (informational)
// ---------------------------------------------------------------------------
package lc3b_pkg;

    localparam int          WORD         = 16;
    localparam logic [1:0]  PCMUX_NPC    = 2'b00;
    localparam logic [1:0]  PCMUX_TARGET = 2'b01;
    localparam logic [1:0]  PCMUX_TRAP   = 2'b10;
    localparam logic [15:0] INSTR_STEP   = 16'd2;
    localparam logic [15:0] RESET_PC     = 16'h3000;

    // Sequential next PC; wraps modulo 2^16 (16'hFFFE -> 16'h0000).
    function automatic logic [WORD-1:0] calc_npc(input logic [WORD-1:0] pc);
        return pc + INSTR_STEP;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// ---------------------------------------------------------------------------
// fetch_stage_if
// Bundles the fetch stage's pipeline-facing signals.
//   master : the enclosing core (drives PC, stalls, redirect info, instr;
//            consumes load enables and DE latch data)
//   slave  : the fetch stage itself
// ---------------------------------------------------------------------------
interface fetch_stage_if;
    import lc3b_pkg::*;

    logic [WORD-1:0] pc;
    logic            dep_stall;
    logic            mem_stall;
    logic            v_de_br_stall;
    logic            v_agex_br_stall;
    logic            v_mem_br_stall;
    logic            imem_r;
    logic [1:0]      mem_pcmux;
    logic [WORD-1:0] target_pc;
    logic [WORD-1:0] trap_pc;
    logic [WORD-1:0] instr;

    logic            ld_pc;
    logic [WORD-1:0] new_pc;
    logic [WORD-1:0] de_npc;
    logic [WORD-1:0] de_ir;
    logic            de_v;
    logic            ld_de;

    modport master (
        output pc, dep_stall, mem_stall, v_de_br_stall, v_agex_br_stall,
               v_mem_br_stall, imem_r, mem_pcmux, target_pc, trap_pc, instr,
        input  ld_pc, new_pc, de_npc, de_ir, de_v, ld_de
    );

    modport slave (
        input  pc, dep_stall, mem_stall, v_de_br_stall, v_agex_br_stall,
               v_mem_br_stall, imem_r, mem_pcmux, target_pc, trap_pc, instr,
        output ld_pc, new_pc, de_npc, de_ir, de_v, ld_de
    );

endinterface

// File: rtl/fetch_stage_pc_mux.sv
// ---------------------------------------------------------------------------
// fetch_pc_mux
// Sequential-PC adder plus the 3:1 next-PC selector driven by the MEM stage.
//   pc_i        : current PC
//   mem_pcmux_i : 00/11 sequential, 01 branch target, 10 trap vector
//   target_pc_i : branch/JSR/JMP target
//   trap_pc_i   : trap vector target
//   npc_o       : pc_i + 2
//   new_pc_o    : selected next PC
// ---------------------------------------------------------------------------
module fetch_pc_mux
    import lc3b_pkg::*;
(
    input  logic [WORD-1:0] pc_i,
    input  logic [1:0]      mem_pcmux_i,
    input  logic [WORD-1:0] target_pc_i,
    input  logic [WORD-1:0] trap_pc_i,
    output logic [WORD-1:0] npc_o,
    output logic [WORD-1:0] new_pc_o
);

    logic [WORD-1:0] npc_s;

    assign npc_s = calc_npc(pc_i);
    assign npc_o = npc_s;

    // Next-PC source select; encoding 11 falls back to the sequential PC.
    always_comb begin
        new_pc_o = npc_s;
        case (mem_pcmux_i)
            PCMUX_NPC:    new_pc_o = npc_s;
            PCMUX_TARGET: new_pc_o = target_pc_i;
            PCMUX_TRAP:   new_pc_o = trap_pc_i;
            default:      new_pc_o = npc_s;
        endcase
    end

endmodule

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// Fetch stage of the 5-stage LC-3b pipeline. Computes the next PC and the DE
// latch inputs; the PC and DE registers themselves live in the core.
//   clk        : pipeline clock
//   rst        : asynchronous, active-high reset; while high the PC is held
//                and DE is loaded with an invalid (flushed) entry
//   fif        : fetch_stage_if.slave (pc, stalls, redirect, instr in;
//                ld_pc, new_pc, de_npc, de_ir, de_v, ld_de out)
//   stall_cnt  : only with FETCH_STALL_CNT_EN defined; saturating count of
//                cycles in which the PC was not loaded
// Configuration macro: FETCH_STALL_CNT_EN
// The default build has no internal state; all outputs are combinational.
// ---------------------------------------------------------------------------
module fetch_stage
    import lc3b_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    fetch_stage_if.slave    fif
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [WORD-1:0] stall_cnt
`endif
);

    logic [WORD-1:0] npc_s;
    logic [WORD-1:0] new_pc_s;
    logic            ctl_in_flight_s;
    logic            ld_pc_s;
    logic            ld_de_s;
    logic            de_v_s;

    fetch_pc_mux u_pc_mux (
        .pc_i        (fif.pc),
        .mem_pcmux_i (fif.mem_pcmux),
        .target_pc_i (fif.target_pc),
        .trap_pc_i   (fif.trap_pc),
        .npc_o       (npc_s),
        .new_pc_o    (new_pc_s)
    );

    assign ctl_in_flight_s = fif.v_de_br_stall | fif.v_agex_br_stall;

    // Load enables and DE valid; a resolving MEM redirect overrides the
    // younger stalls and imem readiness, but nothing moves during mem_stall.
    always_comb begin
        ld_pc_s = 1'b0;
        ld_de_s = 1'b1;
        de_v_s  = 1'b0;
        if (rst) begin
            ld_pc_s = 1'b0;
            ld_de_s = 1'b1;
            de_v_s  = 1'b0;
        end else begin
            ld_pc_s = ~fif.mem_stall &
                      (fif.v_mem_br_stall |
                       (fif.imem_r & ~fif.dep_stall & ~ctl_in_flight_s));
            ld_de_s = ~fif.dep_stall & ~fif.mem_stall;
            de_v_s  = fif.imem_r & ~ctl_in_flight_s & ~fif.v_mem_br_stall;
        end
    end

    assign fif.ld_pc  = ld_pc_s;
    assign fif.new_pc = new_pc_s;
    assign fif.de_npc = npc_s;
    assign fif.de_ir  = fif.instr;
    assign fif.de_v   = de_v_s;
    assign fif.ld_de  = ld_de_s;

`ifdef FETCH_STALL_CNT_EN
    logic [WORD-1:0] stall_cnt_q;
    logic [WORD-1:0] stall_cnt_d;

    // Next count: add one for each cycle the PC is held, sticking at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!ld_pc_s && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= 16'h0000;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    // Without the counter the clock has no consumer.
    logic unused_clk_s;
    assign unused_clk_s = clk;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
// Self-checking bench for fetch_stage: a table of directed vectors, a batch
// of random vectors against a small reference model, a mid-run reset, and
// (with FETCH_STALL_CNT_EN) a stall counter sequence.
// ---------------------------------------------------------------------------
module tb_fetch_stage;
    import lc3b_pkg::*;

    typedef struct {
        logic        rst;
        logic [15:0] pc;
        logic        imem;
        logic        dep;
        logic        mem;
        logic        vde;
        logic        vagex;
        logic        vmem;
        logic [1:0]  mux;
        logic [15:0] tgt;
        logic [15:0] trap;
        logic [15:0] instr;
        logic        e_ld_pc;
        logic [15:0] e_new_pc;
        logic [15:0] e_de_npc;
        logic        e_de_v;
        logic        e_ld_de;
    } vec_t;

    typedef struct {
        string       name;
        logic        ld_pc;
        logic [15:0] new_pc;
        logic [15:0] de_npc;
        logic [15:0] de_ir;
        logic        de_v;
        logic        ld_de;
    } exp_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;
    exp_t sb_q[$];
    vec_t tbl[$];

    fetch_stage_if fif ();

`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_cnt;
    fetch_stage dut (.clk(clk), .rst(rst), .fif(fif), .stall_cnt(stall_cnt));
`else
    fetch_stage dut (.clk(clk), .rst(rst), .fif(fif));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic [15:0] pc,
                                input logic imem, input logic dep, input logic mem,
                                input logic vde, input logic vagex, input logic vmem,
                                input logic [1:0] mux, input logic [15:0] tgt,
                                input logic [15:0] trap, input logic [15:0] instr,
                                input logic eld_pc, input logic [15:0] enew,
                                input logic [15:0] enpc, input logic edev,
                                input logic eld_de);
        vec_t v;
        v.rst = r; v.pc = pc; v.imem = imem; v.dep = dep; v.mem = mem;
        v.vde = vde; v.vagex = vagex; v.vmem = vmem; v.mux = mux;
        v.tgt = tgt; v.trap = trap; v.instr = instr;
        v.e_ld_pc = eld_pc; v.e_new_pc = enew; v.e_de_npc = enpc;
        v.e_de_v = edev; v.e_ld_de = eld_de;
        return v;
    endfunction

    // Reference model written from the behavioural equations.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        r = v;
        r.e_de_npc = v.pc + 16'd2;
        case (v.mux)
            2'b01:   r.e_new_pc = v.tgt;
            2'b10:   r.e_new_pc = v.trap;
            default: r.e_new_pc = v.pc + 16'd2;
        endcase
        if (v.rst) begin
            r.e_ld_pc = 1'b0; r.e_ld_de = 1'b1; r.e_de_v = 1'b0;
        end else begin
            r.e_ld_pc = !v.mem && (v.vmem || (v.imem && !v.dep && !v.vde && !v.vagex));
            r.e_ld_de = !v.dep && !v.mem;
            r.e_de_v  = v.imem && !v.vde && !v.vagex && !v.vmem;
        end
        return r;
    endfunction

    task automatic drive(input string name, input vec_t v);
        exp_t e;
        rst                 = v.rst;
        fif.pc              = v.pc;
        fif.imem_r          = v.imem;
        fif.dep_stall       = v.dep;
        fif.mem_stall       = v.mem;
        fif.v_de_br_stall   = v.vde;
        fif.v_agex_br_stall = v.vagex;
        fif.v_mem_br_stall  = v.vmem;
        fif.mem_pcmux       = v.mux;
        fif.target_pc       = v.tgt;
        fif.trap_pc         = v.trap;
        fif.instr           = v.instr;
        e.name   = name;
        e.ld_pc  = v.e_ld_pc;
        e.new_pc = v.e_new_pc;
        e.de_npc = v.e_de_npc;
        e.de_ir  = v.instr;
        e.de_v   = v.e_de_v;
        e.ld_de  = v.e_ld_de;
        sb_q.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        if (sb_q.size() == 0) begin
            n_cmp = n_cmp + 1;
            n_fail = n_fail + 1;
            $display("FAIL scoreboard: empty queue, expected an entry");
        end else begin
            e = sb_q.pop_front();
            cmp({e.name, ".ld_pc"},  {15'd0, fif.ld_pc}, {15'd0, e.ld_pc});
            cmp({e.name, ".new_pc"}, fif.new_pc,         e.new_pc);
            cmp({e.name, ".de_npc"}, fif.de_npc,         e.de_npc);
            cmp({e.name, ".de_ir"},  fif.de_ir,          e.de_ir);
            cmp({e.name, ".de_v"},   {15'd0, fif.de_v},  {15'd0, e.de_v});
            cmp({e.name, ".ld_de"},  {15'd0, fif.ld_de}, {15'd0, e.ld_de});
        end
    endtask

    task automatic apply(input string name, input vec_t v);
        @(posedge clk);
        #1;
        drive(name, v);
        #3;
        check_out();
    endtask

    initial begin
        vec_t v;
        n_cmp  = 0;
        n_fail = 0;

        // Reset state at time zero with a fetch-ready input pattern.
        drive("reset0", mk(1'b1, 16'h3000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00,
                           16'h4000, 16'h0200, 16'h1234,
                           1'b0, 16'h3002, 16'h3002, 1'b0, 1'b1));
        #2;
        check_out();
`ifdef FETCH_STALL_CNT_EN
        cmp("stall_cnt_reset0", stall_cnt, 16'h0000);
`endif

        //          rst  pc       imem dep  mem  vde  vag  vmem mux    tgt       trap      instr      ldpc new       npc       dev  ldde
        tbl.push_back(mk(1'b0, 16'h3000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 16'h4000, 16'h0200, 16'h1234, 1'b1, 16'h3002, 16'h3002, 1'b1, 1'b1));
        tbl.push_back(mk(1'b0, 16'h3000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 16'h4000, 16'h0200, 16'h1234, 1'b0, 16'h3002, 16'h3002, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 16'h3000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 16'h4000, 16'h0200, 16'h1234, 1'b0, 16'h3002, 16'h3002, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 16'h3000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 16'h4000, 16'h0200, 16'h1234, 1'b0, 16'h3002, 16'h3002, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 16'h3002, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 16'h4000, 16'h0200, 16'h5678, 1'b0, 16'h3004, 16'h3004, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 16'h3002, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 16'h4000, 16'h0200, 16'h5678, 1'b0, 16'h3004, 16'h3004, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 16'h3004, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 16'h4000, 16'h0200, 16'h9ABC, 1'b1, 16'h4000, 16'h3006, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 16'h3004, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 16'h4000, 16'h0200, 16'h9ABC, 1'b1, 16'h0200, 16'h3006, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 16'h3004, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 16'h4000, 16'h0200, 16'h9ABC, 1'b0, 16'h4000, 16'h3006, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 16'h3004, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b01, 16'h4000, 16'h0200, 16'h9ABC, 1'b1, 16'h4000, 16'h3006, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 16'h1000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 16'h4000, 16'h0200, 16'h0F0F, 1'b1, 16'h1002, 16'h1002, 1'b1, 1'b1));
        tbl.push_back(mk(1'b0, 16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 16'h4000, 16'h0200, 16'hFFFF, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b1));
        tbl.push_back(mk(1'b0, 16'h7FFE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 16'h4000, 16'h0200, 16'h0001, 1'b1, 16'h8000, 16'h8000, 1'b0, 1'b1));

        for (int i = 0; i < tbl.size(); i++) begin
            apply($sformatf("vec%0d", i), tbl[i]);
        end

        // Random patterns against the reference model.
        for (int i = 0; i < 40; i++) begin
            v = mk(1'b0, 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom),
                   16'($urandom), 16'($urandom), 16'($urandom),
                   1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
            apply($sformatf("rnd%0d", i), model(v));
        end

        // Reset asserted mid-run overrides stalls and redirect; data still flows.
        apply("rst_mid", mk(1'b1, 16'hFFFE, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01,
                            16'h4000, 16'h0200, 16'hBEEF,
                            1'b0, 16'h4000, 16'h0000, 1'b0, 1'b1));
`ifdef FETCH_STALL_CNT_EN
        cmp("stall_cnt_reset_mid", stall_cnt, 16'h0000);
`endif
        apply("rst_hold", mk(1'b1, 16'h3000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10,
                             16'h4000, 16'h0200, 16'h1234,
                             1'b0, 16'h0200, 16'h3002, 1'b0, 1'b1));

        // Leaving reset during a stall: outputs follow inputs immediately.
        apply("rst_exit", mk(1'b0, 16'h3000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00,
                             16'h4000, 16'h0200, 16'h1234,
                             1'b0, 16'h3002, 16'h3002, 1'b0, 1'b1));
`ifdef FETCH_STALL_CNT_EN
        // Two more stalled edges follow the exit vector, then two fetch cycles.
        repeat (3) @(posedge clk);
        #4;
        cmp("stall_cnt_stalled", stall_cnt, 16'h0003);
        fif.imem_r = 1'b1;
        repeat (2) @(posedge clk);
        #4;
        cmp("stall_cnt_held", stall_cnt, 16'h0003);
`endif

        if (sb_q.size() != 0) begin
            n_cmp = n_cmp + 1;
            n_fail = n_fail + 1;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_cmp, n_fail);
        $finish;
    end

endmodule
